// File: rtl/dmem_bridge.sv
// dmem_bridge: core data-memory port to single-outstanding bus bridge with a one-entry write buffer.
module dmem_bridge (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic        i_read_en,
  input  logic        i_write_en,
  output logic [31:0] o_read_data,
  output logic        o_stall,
  output logic        o_err,
  output logic        o_bus_valid,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);
  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DONE} state_t;
  state_t      state_q, state_d, state_e;
  logic        wb_valid_q, wb_valid_d, wb_valid_e;
  logic [31:0] wb_addr_q, wb_addr_d, wb_data_q, wb_data_d, rdata_q, rdata_d;
  logic        bus_valid_q, bus_valid_d, bus_we_q, bus_we_d, err_q, err_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic        misalign, st, ld, hit, miss, accept, issue;
  always_comb begin
    // While rstn is low the core sees the post-reset state, so stall/data use these views.
    state_e     = rstn ? state_q : IDLE;
    wb_valid_e  = rstn & wb_valid_q;
    misalign    = (i_read_en | i_write_en) & (i_addr[1:0] != 2'b00);
    st          = i_write_en & ~misalign;
    ld          = i_read_en & ~i_write_en & ~misalign;
    hit         = ld & wb_valid_e & (i_addr[31:2] == wb_addr_q[31:2]);
    miss        = ld & ~hit;
    accept      = st & ~wb_valid_e;
    o_stall     = (st & wb_valid_e) | (miss & (state_e != RD_DONE));
    o_read_data = hit ? wb_data_q : (state_e == RD_DONE && !misalign) ? rdata_q : '0;
    state_d     = state_q;
    unique case (state_q)
      IDLE:    state_d = wb_valid_q ? WR_REQ : miss ? RD_REQ : IDLE;
      WR_REQ:  state_d = i_bus_ready ? IDLE : WR_REQ;
      RD_REQ:  state_d = i_bus_ready ? RD_WAIT : RD_REQ;
      RD_WAIT: state_d = i_bus_rvalid ? RD_DONE : RD_WAIT;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wb_valid_d  = (wb_valid_q & ~(state_q == WR_REQ & i_bus_ready)) | accept;
    wb_addr_d   = accept ? i_addr : wb_addr_q;
    wb_data_d   = accept ? i_write_data : wb_data_q;
    rdata_d     = (state_q == RD_WAIT && i_bus_rvalid) ? i_bus_rdata : rdata_q;
    // Requests only start from IDLE; holding otherwise keeps the bus stable until accepted.
    issue       = (state_q == IDLE) && (state_d != IDLE);
    bus_valid_d = (state_d == WR_REQ) || (state_d == RD_REQ);
    bus_we_d    = issue ? (state_d == WR_REQ) : bus_we_q;
    bus_addr_d  = issue ? ((state_d == WR_REQ) ? wb_addr_q : {i_addr[31:2], 2'b00}) : bus_addr_q;
    bus_wdata_d = issue ? ((state_d == WR_REQ) ? wb_data_q : '0) : bus_wdata_q;
    err_d       = misalign | (i_read_en & i_write_en);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      rdata_q     <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      rdata_q     <= rdata_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      err_q       <= err_d;
    end
  end
  assign o_bus_valid = bus_valid_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed cycle-by-cycle checks of dmem_bridge against hand-computed values.
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr, wd, rdata;
  logic        re, we, rdy, rv;
  logic [31:0] o_read_data, o_bus_addr, o_bus_wdata;
  logic        o_stall, o_err, o_bus_valid, o_bus_we;
  int          vectors = 0;
  int          miscompares = 0;
  dmem_bridge dut (
    .clk(clk), .rstn(rstn), .i_addr(addr), .i_write_data(wd), .i_read_en(re), .i_write_en(we),
    .o_read_data(o_read_data), .o_stall(o_stall), .o_err(o_err),
    .o_bus_valid(o_bus_valid), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_ready(rdy), .i_bus_rvalid(rv), .i_bus_rdata(rdata)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    rstn = 0; addr = 0; wd = 0; re = 0; we = 0; rdy = 0; rv = 0; rdata = 0;
    cyc(); #1;
    chk("rst_bus_valid", 32'(o_bus_valid), 0);
    chk("rst_bus_we", 32'(o_bus_we), 0);
    chk("rst_bus_addr", o_bus_addr, 0);
    chk("rst_bus_wdata", o_bus_wdata, 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_stall_idle", 32'(o_stall), 0);
    re = 1; addr = 32'h40; #1;
    chk("rst_load_stall", 32'(o_stall), 1);
    chk("rst_load_data", o_read_data, 0);
    re = 0; we = 1; #1;
    chk("rst_store_nostall", 32'(o_stall), 0);
    we = 0;
    cyc(); rstn = 1;
    // store drains two cycles later for one cycle with ready held
    cyc(); rdy = 1; we = 1; addr = 32'h100; wd = 32'hDEADBEEF; #1;
    chk("st1_stall", 32'(o_stall), 0);
    cyc(); we = 0; #1;
    chk("st1_valid_n1", 32'(o_bus_valid), 0);
    cyc(); #1;
    chk("st1_valid_n2", 32'(o_bus_valid), 1);
    chk("st1_we", 32'(o_bus_we), 1);
    chk("st1_addr", o_bus_addr, 32'h100);
    chk("st1_wdata", o_bus_wdata, 32'hDEADBEEF);
    cyc(); #1;
    chk("st1_valid_n3", 32'(o_bus_valid), 0);
    // misaligned load then buffer hit
    cyc(); rdy = 0; we = 1; addr = 32'h100; wd = 32'hDEADBEEF; #1;
    chk("st2_stall", 32'(o_stall), 0);
    cyc(); we = 0; re = 1; addr = 32'h102; #1;
    chk("mis_stall", 32'(o_stall), 0);
    chk("mis_data", o_read_data, 0);
    chk("mis_err_same", 32'(o_err), 0);
    cyc(); addr = 32'h100; #1;
    chk("mis_err_pulse", 32'(o_err), 1);
    chk("hit_stall", 32'(o_stall), 0);
    chk("hit_data", o_read_data, 32'hDEADBEEF);
    cyc(); re = 0; #1;
    chk("mis_err_clear", 32'(o_err), 0);
    chk("hold_valid", 32'(o_bus_valid), 1);
    chk("hold_addr", o_bus_addr, 32'h100);
    rdy = 1;
    cyc(); #1;
    chk("st2_drained", 32'(o_bus_valid), 0);
    // back-to-back stores, ready delayed
    cyc(); rdy = 0; we = 1; addr = 32'h20; wd = 32'h11111111; #1;
    chk("bb_first_stall", 32'(o_stall), 0);
    cyc(); addr = 32'h24; wd = 32'h22222222; #1;
    chk("bb_second_stall1", 32'(o_stall), 1);
    cyc(); #1;
    chk("bb_second_stall2", 32'(o_stall), 1);
    chk("bb_w1_addr", o_bus_addr, 32'h20);
    chk("bb_w1_wdata", o_bus_wdata, 32'h11111111);
    cyc(); #1;
    chk("bb_second_stall3", 32'(o_stall), 1);
    chk("bb_w1_stable", o_bus_addr, 32'h20);
    cyc(); rdy = 1; #1;
    chk("bb_second_stall4", 32'(o_stall), 1);
    cyc(); #1;
    chk("bb_second_accept", 32'(o_stall), 0);
    chk("bb_gap", 32'(o_bus_valid), 0);
    cyc(); we = 0; #1;
    chk("bb_gap2", 32'(o_bus_valid), 0);
    cyc(); #1;
    chk("bb_w2_valid", 32'(o_bus_valid), 1);
    chk("bb_w2_addr", o_bus_addr, 32'h24);
    chk("bb_w2_wdata", o_bus_wdata, 32'h22222222);
    cyc(); #1;
    chk("bb_done", 32'(o_bus_valid), 0);
    // minimum-latency load miss; rvalid outside RD_WAIT ignored
    cyc(); rdy = 0; re = 1; addr = 32'h80; #1;
    chk("lm_stall_n", 32'(o_stall), 1);
    chk("lm_valid_n", 32'(o_bus_valid), 0);
    cyc(); rdy = 1; rv = 1; rdata = 32'hFFFFFFFF; #1;
    chk("lm_valid_n1", 32'(o_bus_valid), 1);
    chk("lm_we_n1", 32'(o_bus_we), 0);
    chk("lm_addr_n1", o_bus_addr, 32'h80);
    cyc(); rdata = 32'hA5A5A5A5; #1;
    chk("lm_valid_n2", 32'(o_bus_valid), 0);
    chk("lm_stall_n2", 32'(o_stall), 1);
    chk("lm_data_n2", o_read_data, 0);
    cyc(); rv = 0; #1;
    chk("lm_stall_n3", 32'(o_stall), 0);
    chk("lm_data_n3", o_read_data, 32'hA5A5A5A5);
    cyc(); re = 0; #1;
    chk("lm_data_after", o_read_data, 0);
    // load miss behind a buffered store: write drains first
    cyc(); rdy = 0; we = 1; addr = 32'h300; wd = 32'hCAFE0001; #1;
    chk("ord_store_stall", 32'(o_stall), 0);
    cyc(); we = 0; re = 1; addr = 32'h200; #1;
    chk("ord_load_stall", 32'(o_stall), 1);
    cyc(); #1;
    chk("ord_w_valid", 32'(o_bus_valid), 1);
    chk("ord_w_we", 32'(o_bus_we), 1);
    chk("ord_w_addr", o_bus_addr, 32'h300);
    rdy = 1;
    cyc(); #1;
    chk("ord_gap", 32'(o_bus_valid), 0);
    chk("ord_gap_stall", 32'(o_stall), 1);
    cyc(); #1;
    chk("ord_r_valid", 32'(o_bus_valid), 1);
    chk("ord_r_we", 32'(o_bus_we), 0);
    chk("ord_r_addr", o_bus_addr, 32'h200);
    cyc(); rv = 1; rdata = 32'h12345678; #1;
    chk("ord_wait_stall", 32'(o_stall), 1);
    cyc(); rv = 0; #1;
    chk("ord_done_stall", 32'(o_stall), 0);
    chk("ord_done_data", o_read_data, 32'h12345678);
    cyc(); re = 0;
    // reset during RD_WAIT, stray rvalid afterwards
    cyc(); re = 1; addr = 32'h400; rdy = 1;
    cyc();
    cyc(); rstn = 0; re = 0;
    cyc(); rstn = 1; #1;
    chk("rw_valid", 32'(o_bus_valid), 0);
    chk("rw_stall", 32'(o_stall), 0);
    chk("rw_err", 32'(o_err), 0);
    rv = 1; rdata = 32'h00000BAD;
    cyc(); rv = 0; #1;
    chk("rw_stray_data", o_read_data, 0);
    chk("rw_stray_valid", 32'(o_bus_valid), 0);
    chk("rw_stray_stall", 32'(o_stall), 0);
    // reset discards a buffered store
    cyc(); rdy = 0; we = 1; addr = 32'h500; wd = 32'h55; #1;
    chk("rb_store_stall", 32'(o_stall), 0);
    cyc(); we = 0; rstn = 0; re = 1; #1;
    chk("rb_inrst_stall", 32'(o_stall), 1);
    chk("rb_inrst_data", o_read_data, 0);
    cyc(); rstn = 1; #1;
    chk("rb_after_stall", 32'(o_stall), 1);
    chk("rb_after_data", o_read_data, 0);
    re = 0;
    cyc(); #1;
    chk("rb_no_bus", 32'(o_bus_valid), 0);
    // read and write together
    cyc(); re = 1; we = 1; addr = 32'h10; wd = 32'h77; #1;
    chk("both_stall", 32'(o_stall), 0);
    cyc(); re = 0; we = 0; #1;
    chk("both_err", 32'(o_err), 1);
    chk("both_no_read", 32'(o_bus_valid), 0);
    cyc(); re = 1; #1;
    chk("both_err_once", 32'(o_err), 0);
    chk("both_w_valid", 32'(o_bus_valid), 1);
    chk("both_w_we", 32'(o_bus_we), 1);
    chk("both_w_addr", o_bus_addr, 32'h10);
    chk("both_w_wdata", o_bus_wdata, 32'h77);
    chk("both_hit", o_read_data, 32'h77);
    rdy = 1; re = 0;
    cyc(); #1;
    chk("both_done", 32'(o_bus_valid), 0);
    // misaligned store is dropped
    cyc(); we = 1; addr = 32'h103; wd = 32'h99; #1;
    chk("ms_stall", 32'(o_stall), 0);
    cyc(); we = 0; #1;
    chk("ms_err", 32'(o_err), 1);
    cyc(); #1;
    chk("ms_no_bus", 32'(o_bus_valid), 0);
    chk("ms_err_clear", 32'(o_err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
